// File: rtl/spi_xfer_pkg.sv
// rtl/spi_xfer_pkg.sv - shared constants and FSM encoding for the SPI transfer arbiter
package spi_xfer_pkg;

    localparam int WORD_W_DEF    = 18;
    localparam int MAX_WORDS_DEF = 2;
    localparam int CNT_W_DEF     = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CHECK   = 3'd1;
    localparam state_t ST_ISSUE   = 3'd2;
    localparam state_t ST_WAIT_RX = 3'd3;
    localparam state_t ST_GAP     = 3'd4;

    function automatic logic count_legal(input int unsigned cnt, input int unsigned max_words);
        return (cnt != 0) && (cnt <= max_words);
    endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// rtl/spi_rr_arb2.sv - two-way round-robin arbiter with a registered last-served pointer
module spi_rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       last
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || last_q)) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
        last_d = last_q;
        if (gnt[0]) begin
            last_d = 1'b0;
        end else if (gnt[1]) begin
            last_d = 1'b1;
        end
    end

    // Pointer starts at 1 so requester 0 wins the first contest.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last = last_q;

endmodule

// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - shares one single-CS SPI master between two requesters,
// issuing words, routing RX words back and enforcing an idle gap between transactions
module spi_xfer_arbiter
    import spi_xfer_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int GAP_CYC   = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic              i_Req0_Valid,
    input  logic [CNT_W-1:0]  i_Req0_Count,
    input  logic [WORD_W-1:0] i_Req0_Word,
    input  logic              i_Req0_Word_Valid,
    output logic              o_Req0_Word_Ack,
    output logic              o_Req0_Grant,
    output logic              o_Req0_RX_DV,
    output logic              o_Req0_Done,
    output logic              o_Req0_Err,
    input  logic              i_Req1_Valid,
    input  logic [CNT_W-1:0]  i_Req1_Count,
    input  logic [WORD_W-1:0] i_Req1_Word,
    input  logic              i_Req1_Word_Valid,
    output logic              o_Req1_Word_Ack,
    output logic              o_Req1_Grant,
    output logic              o_Req1_RX_DV,
    output logic              o_Req1_Done,
    output logic              o_Req1_Err,
    output logic [WORD_W-1:0] o_RX_Word,
    output logic [CNT_W-1:0]  o_RX_Index,
    output logic [CNT_W-1:0]  o_TX_Count,
    output logic [WORD_W-1:0] o_TX_Byte,
    output logic              o_TX_DV,
    input  logic              i_TX_Ready,
    input  logic              i_RX_DV,
    input  logic [CNT_W-1:0]  i_RX_Count,
    input  logic [WORD_W-1:0] i_RX_Byte
);

    localparam int GAP_W = 8;

    state_t            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  rcvd_q, rcvd_d;
    logic              chk_err_q, chk_err_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              tx_dv_q, tx_dv_d;
    logic [WORD_W-1:0] tx_byte_q, tx_byte_d;
    logic [CNT_W-1:0]  tx_count_q, tx_count_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        rx_dv_q, rx_dv_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [WORD_W-1:0] rx_word_q, rx_word_d;
    logic [CNT_W-1:0]  rx_index_q, rx_index_d;

    logic [1:0]        arb_gnt;
    logic              owner;
    logic [WORD_W-1:0] cur_word;
    logic              cur_word_valid;

    // The last-served pointer is updated at grant time, so it names the owner.
    spi_rr_arb2 u_arb (
        .clk    (i_Clk),
        .resetn (i_Rst_L),
        .en     (state_q == ST_IDLE),
        .req    ({i_Req1_Valid, i_Req0_Valid}),
        .gnt    (arb_gnt),
        .last   (owner)
    );

    assign cur_word       = owner ? i_Req1_Word : i_Req0_Word;
    assign cur_word_valid = owner ? i_Req1_Word_Valid : i_Req0_Word_Valid;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        count_d    = count_q;
        issued_d   = issued_q;
        rcvd_d     = rcvd_q;
        chk_err_d  = chk_err_q;
        gap_d      = gap_q;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        tx_count_d = tx_count_q;
        ack_d      = 2'b00;
        rx_dv_d    = 2'b00;
        done_d     = 2'b00;
        err_d      = 2'b00;
        rx_word_d  = rx_word_q;
        rx_index_d = rx_index_q;

        case (state_q)
            ST_IDLE: begin
                if (|arb_gnt) begin
                    grant_d   = arb_gnt;
                    count_d   = arb_gnt[1] ? i_Req1_Count : i_Req0_Count;
                    chk_err_d = 1'b0;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // An illegal count spends a second cycle here so Done+Err lands two cycles after Grant.
                if (chk_err_q) begin
                    done_d    = grant_q;
                    err_d     = grant_q;
                    grant_d   = 2'b00;
                    chk_err_d = 1'b0;
                    state_d   = ST_IDLE;
                end else if (!count_legal(32'(count_q), MAX_WORDS)) begin
                    chk_err_d = 1'b1;
                end else begin
                    issued_d = '0;
                    rcvd_d   = '0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (i_TX_Ready && cur_word_valid && (issued_q < count_q)) begin
                    tx_dv_d    = 1'b1;
                    tx_byte_d  = cur_word;
                    tx_count_d = count_q;
                    ack_d      = grant_q;
                    issued_d   = issued_q + CNT_W'(1);
                    state_d    = ST_WAIT_RX;
                end
            end
            ST_WAIT_RX: begin
                if (i_RX_DV) begin
                    rx_word_d  = i_RX_Byte;
                    rx_index_d = i_RX_Count;
                    rx_dv_d    = grant_q;
                    rcvd_d     = rcvd_q + CNT_W'(1);
                    if ((rcvd_q + CNT_W'(1)) == count_q) begin
                        done_d  = grant_q;
                        grant_d = 2'b00;
                        gap_d   = '0;
                        state_d = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            rcvd_q     <= '0;
            chk_err_q  <= 1'b0;
            gap_q      <= '0;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= '0;
            tx_count_q <= '0;
            ack_q      <= '0;
            rx_dv_q    <= '0;
            done_q     <= '0;
            err_q      <= '0;
            rx_word_q  <= '0;
            rx_index_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            rcvd_q     <= rcvd_d;
            chk_err_q  <= chk_err_d;
            gap_q      <= gap_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            tx_count_q <= tx_count_d;
            ack_q      <= ack_d;
            rx_dv_q    <= rx_dv_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rx_word_q  <= rx_word_d;
            rx_index_q <= rx_index_d;
        end
    end

    assign o_Req0_Grant    = grant_q[0];
    assign o_Req1_Grant    = grant_q[1];
    assign o_Req0_Word_Ack = ack_q[0];
    assign o_Req1_Word_Ack = ack_q[1];
    assign o_Req0_RX_DV    = rx_dv_q[0];
    assign o_Req1_RX_DV    = rx_dv_q[1];
    assign o_Req0_Done     = done_q[0];
    assign o_Req1_Done     = done_q[1];
    assign o_Req0_Err      = err_q[0];
    assign o_Req1_Err      = err_q[1];
    assign o_RX_Word       = rx_word_q;
    assign o_RX_Index      = rx_index_q;
    assign o_TX_DV         = tx_dv_q;
    assign o_TX_Byte       = tx_byte_q;
    assign o_TX_Count      = tx_count_q;

endmodule

// File: doc/spi_xfer_arbiter.md
# spi_xfer_arbiter

Sequences the 18-bit single-CS SPI master and shares it between two requesters (for example, a DMA stream path and a control/configuration path). Each requester asks for one chip-select transaction of 1..MAX_WORDS words. The block arbitrates round-robin and feeds words into the master's TX handshake. It routes every received word back to the owning requester and enforces a minimum idle gap between CS transactions.

## Interface
- WORD_W, 18: SPI word width; must equal the master's BIT_PER_TRANSFER.
- MAX_WORDS, 2: maximum words per CS transaction; must equal the master's MAX_BYTES_PER_CS.
- CNT_W, 3: width of word-count and index fields.
- GAP_CYC, 4: minimum i_Clk cycles between one transaction's Done and the next transaction's first o_TX_DV; 0 is legal.

Ports (N = 0, 1):
- i_Clk  in  1  system clock; one clock domain only.
- i_Rst_L  in  1  reset; synchronous, active-low.
- i_ReqN_Valid  in  1  requester N wants a transaction; held until o_ReqN_Done.
- i_ReqN_Count  in  CNT_W  word count; sampled at grant.
- i_ReqN_Word  in  WORD_W  next TX word.
- i_ReqN_Word_Valid  in  1  i_ReqN_Word is valid.
- o_ReqN_Word_Ack  out  1  one-cycle pulse: current word issued to the master.
- o_ReqN_Grant  out  1  requester N owns the master.
- o_ReqN_RX_DV  out  1  one-cycle pulse: o_RX_Word and o_RX_Index are valid for N.
- o_ReqN_Done  out  1  one-cycle pulse: transaction finished.
- o_ReqN_Err  out  1  valid with Done: count was illegal; no SPI activity took place.
- o_RX_Word  out  WORD_W  shared received-word bus.
- o_RX_Index  out  CNT_W  word index within the transaction.
- o_TX_Count  out  CNT_W  to master i_TX_Count.
- o_TX_Byte  out  WORD_W  to master i_TX_Byte.
- o_TX_DV  out  1  to master i_TX_DV.
- i_TX_Ready  in  1  from master o_TX_Ready.
- i_RX_DV  in  1  from master o_RX_DV.
- i_RX_Count  in  CNT_W  from master o_RX_Count.
- i_RX_Byte  in  WORD_W  from master o_RX_Byte.

## Operation
- State machine: IDLE, CHECK, ISSUE, WAIT_RX, GAP.
- IDLE:
  - If any Valid is high, the round-robin arbiter picks the winner.
  - If both are high, the requester not served last wins.
  - The last-served pointer resets to 1, so requester 0 wins the first contest.
  - Grant is asserted and the count is latched; go to CHECK.
- CHECK:
  - If the count is 0 or greater than MAX_WORDS: pulse Done with Err=1, drop Grant, go to IDLE with no GAP.
  - Otherwise: clear the issued and received counters, go to ISSUE.
- ISSUE:
  - When i_TX_Ready=1 and Word_Valid=1: o_TX_DV pulses for one cycle, with o_TX_Byte set to the word and o_TX_Count set to the latched count.
  - Word_Ack pulses in the same cycle; issued is incremented.
  - Go to WAIT_RX.
- WAIT_RX:
  - On i_RX_DV: forward i_RX_Byte and i_RX_Count to the owner and pulse RX_DV; received is incremented.
  - If received reaches the count: pulse Done, drop Grant, go to GAP.
  - Otherwise: go to ISSUE.
- GAP: count GAP_CYC cycles, then go to IDLE. With GAP_CYC=0, go straight to IDLE.
- Only the granted requester's Ack, RX_DV and Done can pulse.
- A non-granted Valid is held pending and does not preempt the current transaction.
- If Valid drops mid-transaction, the drop is ignored and the transaction completes. If Word_Valid stays low, the block stalls in ISSUE with CS held low by the master. There is no timeout.
- An i_RX_DV outside WAIT_RX is ignored.
- Reset mid-transaction forces IDLE on the next edge. The master must share the same reset.

## Timing
- On reset, every output is 0: Grant, Ack, RX_DV, Done, Err, o_TX_DV, o_TX_Byte, o_TX_Count, o_RX_Word, o_RX_Index. State returns to IDLE.
- Grant: registered; high 1 cycle after Valid is sampled in IDLE.
- First o_TX_DV: earliest at 2 cycles after Grant, provided Ready and Word_Valid are both high.
- o_TX_DV: registered; exactly 1 cycle wide, never asserted on consecutive cycles.
- RX path: o_ReqN_RX_DV, o_RX_Word and o_RX_Index are registered, 1 cycle after i_RX_DV.
- Done: coincident with the final RX_DV. Grant falls in the same cycle.
- Next grant: earliest GAP_CYC+1 cycles after Done.
- Illegal count: Done+Err appears 2 cycles after Grant.

## Structure
- Package spi_xfer_pkg holds:
  - the state enum (IDLE, CHECK, ISSUE, WAIT_RX, GAP);
  - default WORD_W, MAX_WORDS and CNT_W constants, shared with the master instantiation.
- Sub-module spi_rr_arb2 is the two-way round-robin arbiter.
  - Inputs: req[1:0] and an enable, asserted only in IDLE.
  - Outputs: a one-hot grant and the last-served pointer.

## Test plan
- Req0 only, Count=2, words 0x3AAAA and 0x15555, master MISO looped:
  - 2 o_TX_DV pulses carrying o_TX_Count=2;
  - 2 Req0_RX_DV pulses with indices 0 and 1;
  - 1 Done with Err=0; Req1 outputs stay 0.
- Both requesters valid in the same cycle from reset:
  - Req0 is served first, Req1 second;
  - the next simultaneous request goes to Req0 again, because Req1 was served last.
- Req1 with Count=0, then Count=3:
  - each request gets Done+Err 2 cycles after Grant;
  - no o_TX_DV is issued.
- Word_Valid held low for 50 cycles after the first word:
  - block stays in ISSUE, no TX_DV;
  - transaction resumes and completes normally once Word_Valid rises.
- GAP_CYC=4:
  - measure 5 cycles from Done to the next Grant;
  - when Req1 asserts during GAP, it is granted only after GAP ends.
- i_Rst_L low for 1 cycle while in WAIT_RX:
  - all outputs are 0 on the next cycle;
  - a fresh Req0 transaction then completes correctly.
